// File: rtl/hazard_scoreboard.sv
// Load-use hazard scoreboard: per-register countdown of outstanding load latency, with combinational stall enables.
// Optional stall-cycle performance counter is built when HAZARD_STALL_COUNTER_EN is defined.
module hazard_scoreboard #(
    parameter int REG_ADDR_W = 3,
    parameter int LOAD_LAT   = 1
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         issue_valid,
    input  logic [REG_ADDR_W-1:0]        issue_rs,
    input  logic [REG_ADDR_W-1:0]        issue_rt,
    input  logic                         issue_uses_rs,
    input  logic                         issue_uses_rt,
    input  logic                         issue_wr_en,
    input  logic [REG_ADDR_W-1:0]        issue_rd,
    input  logic                         issue_is_load,
    input  logic                         mem_wait,
    input  logic                         flush,
    output logic                         PC_write_en,
    output logic                         PR1_IF_ID_write_en,
    output logic                         control_signals_en,
    output logic [(2**REG_ADDR_W)-1:0]   pending_mask,
    output logic [15:0]                  stall_cycles
);

    localparam int NUM_REGS = 2**REG_ADDR_W;
    localparam int CNT_W    = $clog2(LOAD_LAT + 1);
    localparam logic [CNT_W-1:0] LAT_VAL  = CNT_W'(LOAD_LAT);
    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic [CNT_W-1:0]    r_cnt     [NUM_REGS];
    logic [CNT_W-1:0]    w_cnt_nxt [NUM_REGS];
    logic [NUM_REGS-1:0] w_busy;
    logic                w_hazard;
    logic                w_accept;

    // Busy decode of every register counter.
    always_comb begin
        w_busy = {NUM_REGS{1'b0}};
        for (int i = 0; i < NUM_REGS; i++) begin
            w_busy[i] = (r_cnt[i] != CNT_ZERO);
        end
    end

    // rs == rt simply selects the same busy bit twice, so it is never counted double.
    assign w_hazard = issue_valid & ~flush &
                      ((issue_uses_rs & w_busy[issue_rs]) | (issue_uses_rt & w_busy[issue_rt]));
    assign w_accept = issue_valid & ~flush & ~w_hazard & issue_wr_en;

    assign PC_write_en        = ~w_hazard;
    assign PR1_IF_ID_write_en = ~w_hazard;
    assign control_signals_en = ~w_hazard;
    assign pending_mask       = w_busy;

    // Next counter values: allocation of the destination wins over draining.
    always_comb begin
        for (int i = 0; i < NUM_REGS; i++) begin
            w_cnt_nxt[i] = r_cnt[i];
            if (w_accept && (issue_rd == REG_ADDR_W'(i))) begin
                if (issue_is_load) begin
                    w_cnt_nxt[i] = LAT_VAL;
                end else begin
                    w_cnt_nxt[i] = CNT_ZERO;
                end
            end else if (!mem_wait && w_busy[i]) begin
                w_cnt_nxt[i] = r_cnt[i] - CNT_ONE;
            end else begin
                w_cnt_nxt[i] = r_cnt[i];
            end
        end
    end

    // Counter state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                r_cnt[i] <= CNT_ZERO;
            end
        end else begin
            for (int i = 0; i < NUM_REGS; i++) begin
                r_cnt[i] <= w_cnt_nxt[i];
            end
        end
    end

`ifdef HAZARD_STALL_COUNTER_EN
    logic [15:0] r_stall_cycles;

    // Saturating count of edges on which the ID stage was held.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_stall_cycles <= 16'd0;
        end else if (w_hazard && (r_stall_cycles != 16'hFFFF)) begin
            r_stall_cycles <= r_stall_cycles + 16'd1;
        end else begin
            r_stall_cycles <= r_stall_cycles;
        end
    end

    assign stall_cycles = r_stall_cycles;
`else
    assign stall_cycles = 16'd0;
`endif

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Scoreboard bench for hazard_scoreboard: LOAD_LAT=1 and LOAD_LAT=3 instances share one stimulus stream.
module tb_hazard_scoreboard;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic       issue_valid, issue_uses_rs, issue_uses_rt, issue_wr_en, issue_is_load;
    logic       mem_wait, flush;
    logic [2:0] issue_rs, issue_rt, issue_rd;

    logic        pc1, pr1, cs1, pc3, pr3, cs3;
    logic [7:0]  mask1, mask3;
    logic [15:0] sc1, sc3;

    hazard_scoreboard #(.REG_ADDR_W(3), .LOAD_LAT(1)) u_dut1 (
        .clk(clk), .rst(rst), .issue_valid(issue_valid), .issue_rs(issue_rs), .issue_rt(issue_rt),
        .issue_uses_rs(issue_uses_rs), .issue_uses_rt(issue_uses_rt), .issue_wr_en(issue_wr_en),
        .issue_rd(issue_rd), .issue_is_load(issue_is_load), .mem_wait(mem_wait), .flush(flush),
        .PC_write_en(pc1), .PR1_IF_ID_write_en(pr1), .control_signals_en(cs1),
        .pending_mask(mask1), .stall_cycles(sc1));

    hazard_scoreboard #(.REG_ADDR_W(3), .LOAD_LAT(3)) u_dut3 (
        .clk(clk), .rst(rst), .issue_valid(issue_valid), .issue_rs(issue_rs), .issue_rt(issue_rt),
        .issue_uses_rs(issue_uses_rs), .issue_uses_rt(issue_uses_rt), .issue_wr_en(issue_wr_en),
        .issue_rd(issue_rd), .issue_is_load(issue_is_load), .mem_wait(mem_wait), .flush(flush),
        .PC_write_en(pc3), .PR1_IF_ID_write_en(pr3), .control_signals_en(cs3),
        .pending_mask(mask3), .stall_cycles(sc3));

    typedef struct {
        bit          sel3;
        logic        en;
        logic [7:0]  mask;
        bit          chk_sc;
        logic [15:0] sc;
        string       nm;
    } exp_t;

    exp_t q[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    function automatic logic [15:0] sc_exp(input int n);
`ifdef HAZARD_STALL_COUNTER_EN
        return 16'(n);
`else
        return 16'd0;
`endif
    endfunction

    task automatic set_in(input logic v, input logic [2:0] rs, input logic urs,
                          input logic [2:0] rt, input logic urt, input logic wr,
                          input logic [2:0] rd, input logic ld, input logic mw, input logic fl);
        issue_valid = v;   issue_rs = rs; issue_uses_rs = urs;
        issue_rt = rt;     issue_uses_rt = urt;
        issue_wr_en = wr;  issue_rd = rd; issue_is_load = ld;
        mem_wait = mw;     flush = fl;
    endtask

    task automatic idle(input logic mw);
        set_in(1'b0, 3'd0, 1'b0, 3'd0, 1'b0, 1'b0, 3'd0, 1'b0, mw, 1'b0);
    endtask

    task automatic load(input logic [2:0] rd);
        set_in(1'b1, 3'd0, 1'b0, 3'd0, 1'b0, 1'b1, rd, 1'b1, 1'b0, 1'b0);
    endtask

    task automatic expect_out(input bit s3, input logic en, input logic [7:0] m,
                              input bit cs, input logic [15:0] sc, input string nm);
        exp_t e;
        e.sel3 = s3; e.en = en; e.mask = m; e.chk_sc = cs; e.sc = sc; e.nm = nm;
        q.push_back(e);
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    exp_t        m_e;
    logic [2:0]  m_en;
    logic [7:0]  m_mask;
    logic [15:0] m_sc;

    // Monitor: pops one expectation per cycle and compares away from the active edge.
    always @(negedge clk) begin
        if (q.size() > 0) begin
            m_e    = q.pop_front();
            m_en   = m_e.sel3 ? {pc3, pr3, cs3} : {pc1, pr1, cs1};
            m_mask = m_e.sel3 ? mask3 : mask1;
            m_sc   = m_e.sel3 ? sc3 : sc1;
            n_cmp++;
            if (m_en !== {3{m_e.en}}) begin
                n_bad++;
                $display("FAIL %s enables: got %b expected %b", m_e.nm, m_en, {3{m_e.en}});
            end
            n_cmp++;
            if (m_mask !== m_e.mask) begin
                n_bad++;
                $display("FAIL %s pending_mask: got %h expected %h", m_e.nm, m_mask, m_e.mask);
            end
            if (m_e.chk_sc) begin
                n_cmp++;
                if (m_sc !== m_e.sc) begin
                    n_bad++;
                    $display("FAIL %s stall_cycles: got %0d expected %0d", m_e.nm, m_sc, m_e.sc);
                end
            end
        end
    end

    initial begin
        idle(1'b0);
        tick;
        expect_out(1'b0, 1'b1, 8'h00, 1'b1, 16'd0, "rst_d1");            tick;
        expect_out(1'b1, 1'b1, 8'h00, 1'b1, 16'd0, "rst_d3");            tick;
        rst = 1'b0;

        // Single load-use stall with LOAD_LAT=1
        load(3'd3);
        expect_out(1'b0, 1'b1, 8'h00, 1'b1, 16'd0, "r22_load");          tick;
        set_in(1'b1, 3'd3, 1'b1, 3'd0, 1'b0, 1'b1, 3'd1, 1'b0, 1'b0, 1'b0);
        expect_out(1'b0, 1'b0, 8'h08, 1'b0, 16'd0, "r22_stall");         tick;
        expect_out(1'b0, 1'b1, 8'h00, 1'b1, sc_exp(1), "r22_release");   tick;

        // Unused rs pointing at a pending register
        load(3'd3);
        expect_out(1'b0, 1'b1, 8'h00, 1'b0, 16'd0, "r27_load");          tick;
        set_in(1'b1, 3'd3, 1'b0, 3'd1, 1'b1, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0);
        expect_out(1'b0, 1'b1, 8'h08, 1'b0, 16'd0, "r27_no_stall");      tick;

        // rs == rt on the same pending register
        load(3'd6);
        expect_out(1'b0, 1'b1, 8'h00, 1'b0, 16'd0, "r15_load");          tick;
        set_in(1'b1, 3'd6, 1'b1, 3'd6, 1'b1, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0);
        expect_out(1'b0, 1'b0, 8'h40, 1'b0, 16'd0, "r15_stall");         tick;
        expect_out(1'b0, 1'b1, 8'h00, 1'b1, sc_exp(2), "r15_release");   tick;

        // ALU write supersedes a pending load (mem_wait would otherwise hold it)
        load(3'd2);
        expect_out(1'b0, 1'b1, 8'h00, 1'b0, 16'd0, "r24_load");          tick;
        set_in(1'b1, 3'd0, 1'b0, 3'd0, 1'b0, 1'b1, 3'd2, 1'b0, 1'b1, 1'b0);
        expect_out(1'b0, 1'b1, 8'h04, 1'b0, 16'd0, "r24_alu");           tick;
        set_in(1'b1, 3'd2, 1'b1, 3'd0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0);
        expect_out(1'b0, 1'b1, 8'h00, 1'b0, 16'd0, "r24_reader");        tick;

        // Flushed dependent: no stall, no allocation of r7, r5 keeps draining
        load(3'd5);
        expect_out(1'b0, 1'b1, 8'h00, 1'b0, 16'd0, "r25_load");          tick;
        set_in(1'b1, 3'd5, 1'b1, 3'd0, 1'b0, 1'b1, 3'd7, 1'b1, 1'b1, 1'b1);
        expect_out(1'b0, 1'b1, 8'h20, 1'b0, 16'd0, "r25_flush");         tick;
        idle(1'b1);
        expect_out(1'b0, 1'b1, 8'h20, 1'b0, 16'd0, "r25_hold");          tick;
        idle(1'b0);
        expect_out(1'b0, 1'b1, 8'h20, 1'b0, 16'd0, "r25_drain");         tick;
        expect_out(1'b0, 1'b1, 8'h00, 1'b1, sc_exp(2), "r25_empty");     tick;

        rst = 1'b1;
        expect_out(1'b1, 1'b1, 8'h00, 1'b1, 16'd0, "rst2_d3");           tick;
        rst = 1'b0;

        // LOAD_LAT=3 with two mem_wait cycles: five stalls
        load(3'd5);
        expect_out(1'b1, 1'b1, 8'h00, 1'b0, 16'd0, "r23_load");          tick;
        for (int k = 0; k < 5; k++) begin
            set_in(1'b1, 3'd5, 1'b1, 3'd0, 1'b0, 1'b0, 3'd0, 1'b0, (k < 2) ? 1'b1 : 1'b0, 1'b0);
            expect_out(1'b1, 1'b0, 8'h20, 1'b0, 16'd0, $sformatf("r23_stall%0d", k));
            tick;
        end
        expect_out(1'b1, 1'b1, 8'h00, 1'b1, sc_exp(5), "r23_release");   tick;

        // Reset while cnt[4]=2 and a dependent is stalled
        load(3'd4);
        expect_out(1'b1, 1'b1, 8'h00, 1'b0, 16'd0, "r26_load");          tick;
        set_in(1'b1, 3'd4, 1'b1, 3'd0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0);
        expect_out(1'b1, 1'b0, 8'h10, 1'b0, 16'd0, "r26_cnt3");          tick;
        set_in(1'b1, 3'd4, 1'b1, 3'd0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b1, 1'b0);
        expect_out(1'b1, 1'b0, 8'h10, 1'b0, 16'd0, "r26_cnt2");          tick;
        rst = 1'b1;
        expect_out(1'b1, 1'b1, 8'h00, 1'b1, 16'd0, "r26_rst");           tick;
        expect_out(1'b0, 1'b1, 8'h00, 1'b1, 16'd0, "r26_rst_d1");        tick;
        rst = 1'b0;
        idle(1'b0);

        for (int k = 0; k < 4 && q.size() != 0; k++) tick;
        if (q.size() != 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL drain: got %0d pending expectations expected 0", q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/hazard_scoreboard.md
HAZARD_SCOREBOARD -- requirements
Module: hazard_scoreboard

Interface
REQ-001 The block SHALL have parameter REG_ADDR_W, default 3, register address width; NUM_REGS = 2**REG_ADDR_W.
REQ-002 The block SHALL have parameter LOAD_LAT, default 1, range 1..15, bubbles a load result needs before it is forwardable; CNT_W = $clog2(LOAD_LAT+1).
REQ-003 The block SHALL have ports:
- clk  input  1  sole clock, rising edge
- rst  input  1  asynchronous, active-high reset
- issue_valid  input  1  instruction present in ID
- issue_rs, issue_rt  input  REG_ADDR_W each  ID source addresses
- issue_uses_rs, issue_uses_rt  input  1 each  source actually read
- issue_wr_en  input  1  ID instruction writes issue_rd
- issue_rd  input  REG_ADDR_W  ID destination
- issue_is_load  input  1  ID instruction is a memory read
- mem_wait  input  1  memory stage stalled this cycle
- flush  input  1  squash ID instruction this cycle
- PC_write_en, PR1_IF_ID_write_en, control_signals_en  output  1 each  high = advance / insert no bubble
- pending_mask  output  NUM_REGS  bit i high when cnt[i] != 0
- stall_cycles  output  16  stall-cycle performance count

Function
REQ-004 The block SHALL hold one CNT_W-bit counter cnt[i] per register, i = 0..NUM_REGS-1; R0 is treated like every other register.
REQ-005 hazard SHALL be combinational: issue_valid & !flush & ((issue_uses_rs & cnt[issue_rs]!=0) | (issue_uses_rt & cnt[issue_rt]!=0)).
REQ-006 All three enable outputs SHALL equal !hazard in the same cycle; no registered delay.
REQ-007 accept SHALL be issue_valid & !flush & !hazard & issue_wr_en.
REQ-008 On accept with issue_is_load = 1, cnt[issue_rd] SHALL load LOAD_LAT at the next edge.
REQ-009 On accept with issue_is_load = 0, cnt[issue_rd] SHALL clear to 0 at the next edge (a younger ALU write supersedes a pending load, no false stall).
REQ-010 Every non-allocated counter with value > 0 SHALL decrement by 1 per edge when mem_wait = 0 and hold when mem_wait = 1.
REQ-011 Allocation SHALL take priority over decrement on the same register in the same cycle.
REQ-012 Counters SHALL never wrap below 0 or exceed LOAD_LAT.
REQ-013 A stalled or flushed instruction SHALL NOT allocate; flush SHALL NOT clear counters (in-flight older loads still complete).
REQ-014 With LOAD_LAT = 1, a load accepted in cycle t followed by a dependent instruction SHALL produce exactly one stall cycle (t+1), and the dependent instruction SHALL advance in t+2.
REQ-015 issue_rs == issue_rt SHALL be evaluated as one source; no double counting.
REQ-016 pending_mask SHALL be a combinational decode of the counters.

Reset
REQ-017 rst high SHALL asynchronously clear every cnt[i] and stall_cycles to 0.
REQ-018 During and after reset, with cnt = 0, the enable outputs SHALL be 1 and pending_mask SHALL be 0.
REQ-019 A reset asserted mid-stall SHALL release the stall immediately (combinationally via the cleared counters).

Configuration
REQ-020 With macro HAZARD_STALL_COUNTER_EN defined, stall_cycles SHALL increment by 1 on each edge where hazard = 1, saturate at 16'hFFFF, and clear only on rst.
REQ-021 Without HAZARD_STALL_COUNTER_EN, stall_cycles SHALL be tied to 0 and no counter register SHALL be synthesised.

Verification
REQ-022 Load r3 accepted at t (LOAD_LAT=1), next instruction uses rs=r3 -> enables 0 at t+1, 1 at t+2, pending_mask=8'h08 at t+1.
REQ-023 LOAD_LAT=3, load r5, mem_wait high for 2 cycles after issue, dependent on r5 -> 5 stall cycles, then release; stall_cycles=5 with macro.
REQ-024 Load r2 then ALU write r2 accepted before the load drains, then reader of r2 -> cnt[2]=0, no stall for the reader.
REQ-025 Dependent instruction presented with flush=1 -> enables stay 1; counters unchanged, no allocation.
REQ-026 rst pulsed while cnt[4]=2 and a dependent instruction is stalled -> enables rise in the same cycle, pending_mask=0, stall_cycles=0.
REQ-027 Reader with uses_rs=0, rs=r3 pending, uses_rt=1, rt=r1 not pending -> no stall.
